// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state codes, next-PC source
// encoding, default reset/exception addresses and an alignment helper.
package pc_seq_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  typedef enum logic [2:0] {
    SRC_SEQ = 3'd0,
    SRC_BR  = 3'd1,
    SRC_J   = 3'd2,
    SRC_JR  = 3'd3,
    SRC_EXC = 3'd4
  } pc_src_e;

  function automatic logic misaligned(input logic [1:0] lsbs);
    return (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select with word-alignment force and misalignment flag.
// The exception source exists only when PC_EXC_EN is defined.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int N_BITS = 32
`ifdef PC_EXC_EN
  , parameter logic [N_BITS-1:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input  logic [N_BITS-1:0] pc_plus4_i,
  input  logic              br_i,
  input  logic [N_BITS-1:0] br_target_i,
  input  logic              j_i,
  input  logic [N_BITS-1:0] j_target_i,
  input  logic              jr_i,
  input  logic [N_BITS-1:0] jr_target_i,
`ifdef PC_EXC_EN
  input  logic              exc_i,
`endif
  output logic [N_BITS-1:0] next_pc_o,
  output logic              align_err_o
);

  pc_src_e             src_s;
  logic [N_BITS-1:0]   target_s;

  // Priority encode the redirect requests
  always_comb begin
    src_s = SRC_SEQ;
`ifdef PC_EXC_EN
    if (exc_i) begin
      src_s = SRC_EXC;
    end else
`endif
    if (jr_i) begin
      src_s = SRC_JR;
    end else if (j_i) begin
      src_s = SRC_J;
    end else if (br_i) begin
      src_s = SRC_BR;
    end else begin
      src_s = SRC_SEQ;
    end
  end

  // Route the selected source address
  always_comb begin
    target_s = pc_plus4_i;
    case (src_s)
      SRC_BR:  target_s = br_target_i;
      SRC_J:   target_s = j_target_i;
      SRC_JR:  target_s = jr_target_i;
`ifdef PC_EXC_EN
      SRC_EXC: target_s = EXC_VECTOR;
`endif
      default: target_s = pc_plus4_i;
    endcase
  end

  // pc+4 is always aligned, so only redirect targets can raise the flag
  assign next_pc_o   = {target_s[N_BITS-1:2], 2'b00};
  assign align_err_o = (src_s != SRC_SEQ) && misaligned(target_s[1:0]);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter register and BOOT/FETCH/HOLD fetch FSM with req/ack handshake.
// Optional exception redirect and EPC capture enabled by PC_EXC_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter logic [N_BITS-1:0] RESET_PC = RESET_PC_DEF
`ifdef PC_EXC_EN
  , parameter logic [N_BITS-1:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [N_BITS-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [N_BITS-1:0] jump_target_i,
  input  logic              jr_i,
  input  logic [N_BITS-1:0] jr_target_i,
  input  logic              imem_ack_i,
`ifdef PC_EXC_EN
  input  logic              exc_i,
  output logic [N_BITS-1:0] epc_o,
`endif
  output logic              imem_req_o,
  output logic [N_BITS-1:0] pc_o,
  output logic [N_BITS-1:0] pc_plus4_o,
  output logic              pc_valid_o,
  output logic              align_err_o
);

  logic [1:0]        state_q, state_d;
  logic [N_BITS-1:0] pc_q, pc_d;
  logic [N_BITS-1:0] pc_plus4_s;
  logic [N_BITS-1:0] next_pc_s;
  logic              mux_err_s;
  logic              advance_s;
`ifdef PC_EXC_EN
  logic [N_BITS-1:0] epc_q, epc_d;
`endif

  assign pc_plus4_s = pc_q + {{(N_BITS-3){1'b0}}, 3'd4};
  assign advance_s  = ((state_q == FETCH) && imem_ack_i && !stall_i) ||
                      ((state_q == HOLD) && !stall_i);

  pc_next_mux #(
    .N_BITS      (N_BITS)
`ifdef PC_EXC_EN
    , .EXC_VECTOR(EXC_VECTOR)
`endif
  ) u_next_mux (
    .pc_plus4_i  (pc_plus4_s),
    .br_i        (branch_taken_i),
    .br_target_i (branch_target_i),
    .j_i         (jump_i),
    .j_target_i  (jump_target_i),
    .jr_i        (jr_i),
    .jr_target_i (jr_target_i),
`ifdef PC_EXC_EN
    .exc_i       (exc_i),
`endif
    .next_pc_o   (next_pc_s),
    .align_err_o (mux_err_s)
  );

  // FSM transitions; stall only matters once the current fetch is acked
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ack_i) begin
          state_d = stall_i ? HOLD : FETCH;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Redirects are honoured only in the advance cycle
  always_comb begin
    pc_d = pc_q;
`ifdef PC_EXC_EN
    epc_d = epc_q;
`endif
    if (advance_s) begin
      pc_d = next_pc_s;
`ifdef PC_EXC_EN
      if (exc_i) begin
        epc_d = pc_q;
      end else begin
        epc_d = epc_q;
      end
`endif
    end else begin
      pc_d = pc_q;
    end
  end

  // State and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
`ifdef PC_EXC_EN
      epc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_EXC_EN
      epc_q   <= epc_d;
`endif
    end
  end

  assign imem_req_o  = (state_q == FETCH);
  assign pc_valid_o  = (state_q == FETCH) && imem_ack_i;
  assign align_err_o = advance_s && mux_err_s;
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_plus4_s;
`ifdef PC_EXC_EN
  assign epc_o       = epc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; exception steps run only
// when PC_EXC_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic        imem_ack_i;
  logic        imem_req_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pc_valid_o;
  logic        align_err_o;
`ifdef PC_EXC_EN
  logic        exc_i;
  logic [31:0] epc_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .imem_ack_i      (imem_ack_i),
`ifdef PC_EXC_EN
    .exc_i           (exc_i),
    .epc_o           (epc_o),
`endif
    .imem_req_o      (imem_req_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .pc_valid_o      (pc_valid_o),
    .align_err_o     (align_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; imem_ack_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = 32'h0;
    jump_i = 1'b0; jump_target_i = 32'h0;
    jr_i = 1'b0; jr_target_i = 32'h0;
`ifdef PC_EXC_EN
    exc_i = 1'b0;
`endif
    #3;
    chk("rst_pc", pc_o, 32'h0040_0000);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, pc_valid_o}, 32'd0);
    chk("rst_align", {31'd0, align_err_o}, 32'd0);
`ifdef PC_EXC_EN
    chk("rst_epc", epc_o, 32'h0);
`endif
    repeat (2) cyc();

    // Test 1: boot cycle, then back-to-back acks
    reset = 1'b0;
    #1;
    chk("boot_req_c1", {31'd0, imem_req_o}, 32'd0);
    cyc();
    imem_ack_i = 1'b1;
    #1;
    chk("fetch_req_c2", {31'd0, imem_req_o}, 32'd1);
    chk("t1_pc0", pc_o, 32'h0040_0000);
    chk("t1_valid0", {31'd0, pc_valid_o}, 32'd1);
    chk("t1_plus4", pc_plus4_o, 32'h0040_0004);
    cyc();
    chk("t1_pc1", pc_o, 32'h0040_0004);
    chk("t1_valid1", {31'd0, pc_valid_o}, 32'd1);
    cyc();
    chk("t1_pc2", pc_o, 32'h0040_0008);
    chk("t1_valid2", {31'd0, pc_valid_o}, 32'd1);

    // Test 2: ack withheld for 3 cycles
    imem_ack_i = 1'b0;
    #1;
    chk("t2_novalid", {31'd0, pc_valid_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_wait_pc", pc_o, 32'h0040_0008);
      chk("t2_wait_req", {31'd0, imem_req_o}, 32'd1);
    end
    imem_ack_i = 1'b1;
    #1;
    chk("t2_ack_valid", {31'd0, pc_valid_o}, 32'd1);
    cyc();
    imem_ack_i = 1'b0;
    #1;
    chk("t2_pc_next", pc_o, 32'h0040_000C);
    chk("t2_valid_off", {31'd0, pc_valid_o}, 32'd0);

    // Test 3: ack with stall enters HOLD; redirects ignored while held
    imem_ack_i = 1'b1; stall_i = 1'b1;
    #1;
    chk("t3_ack_valid", {31'd0, pc_valid_o}, 32'd1);
    cyc();
    imem_ack_i = 1'b0;
    jump_i = 1'b1; jump_target_i = 32'h0050_0000;
    #1;
    chk("t3_hold_req", {31'd0, imem_req_o}, 32'd0);
    chk("t3_hold_pc", pc_o, 32'h0040_000C);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_hold_pc_k", pc_o, 32'h0040_000C);
      chk("t3_hold_req_k", {31'd0, imem_req_o}, 32'd0);
    end
    jump_i = 1'b0;
    stall_i = 1'b0;
    #1;
    chk("t3_rel_align", {31'd0, align_err_o}, 32'd0);
    cyc();
    chk("t3_rel_pc", pc_o, 32'h0040_0010);
    chk("t3_rel_req", {31'd0, imem_req_o}, 32'd1);

`ifdef PC_EXC_EN
    // Test 6b: exception at the advance cycle, then one outside it
    exc_i = 1'b1; imem_ack_i = 1'b1; jr_i = 1'b1; jr_target_i = 32'h0040_0200;
    cyc();
    exc_i = 1'b0; imem_ack_i = 1'b0; jr_i = 1'b0;
    #1;
    chk("exc_pc", pc_o, 32'h8000_0180);
    chk("exc_epc", epc_o, 32'h0040_0010);
    exc_i = 1'b1;
    cyc();
    exc_i = 1'b0;
    #1;
    chk("exc_ign_pc", pc_o, 32'h8000_0180);
    chk("exc_ign_epc", epc_o, 32'h0040_0010);
`endif

    // Test 4: jr beats jump and branch; misaligned target
    imem_ack_i = 1'b1;
    jr_i = 1'b1; jr_target_i = 32'h0040_0102;
    jump_i = 1'b1; jump_target_i = 32'h0060_0000;
    branch_taken_i = 1'b1; branch_target_i = 32'h0070_0000;
    #1;
    chk("t4_align_on", {31'd0, align_err_o}, 32'd1);
    cyc();
    jr_i = 1'b0; imem_ack_i = 1'b0;
    #1;
    chk("t4_pc", pc_o, 32'h0040_0100);
    chk("t4_align_off", {31'd0, align_err_o}, 32'd0);

    // jump beats branch, aligned target
    imem_ack_i = 1'b1; jump_target_i = 32'h0040_0300; branch_target_i = 32'h0040_0203;
    #1;
    chk("jmp_align", {31'd0, align_err_o}, 32'd0);
    cyc();
    jump_i = 1'b0;
    #1;
    chk("jmp_pc", pc_o, 32'h0040_0300);
    // branch alone, misaligned
    chk("br_align", {31'd0, align_err_o}, 32'd1);
    cyc();
    branch_taken_i = 1'b0;
    jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
    #1;
    chk("br_pc", pc_o, 32'h0040_0200);
    cyc();
    jump_i = 1'b0;
    #1;
    chk("top_pc", pc_o, 32'hFFFF_FFFC);
    chk("top_plus4", pc_plus4_o, 32'h0000_0000);

    // Test 5: sequential wrap
    chk("wrap_align", {31'd0, align_err_o}, 32'd0);
    cyc();
    imem_ack_i = 1'b0;
    #1;
    chk("wrap_pc", pc_o, 32'h0000_0000);
    chk("wrap_plus4", pc_plus4_o, 32'h0000_0004);

    // Test 6a: asynchronous reset mid-fetch
    chk("pre_rst_req", {31'd0, imem_req_o}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("mid_rst_pc", pc_o, 32'h0040_0000);
`ifdef PC_EXC_EN
    chk("mid_rst_epc", epc_o, 32'h0);
`endif
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
